mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 58 +++++
 tb/tb_mem_copy_dma.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: byte-wise memory-to-memory copy engine, two cycles per byte
module mem_copy_dma #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [ADDR_WIDTH:0]   r_rem;
  // copy sequencer: one READ then one WRITE per byte, pointers advance on WRITE exit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_src   <= src;
          r_dst   <= dst;
          r_rem   <= len;
          r_state <= (len != '0) ? READ : DONE;
        end
        READ: r_state <= WRITE;
        WRITE: begin
          r_src   <= r_src + ADDR_WIDTH'(1);
          r_dst   <= r_dst + ADDR_WIDTH'(1);
          r_rem   <= r_rem - (ADDR_WIDTH+1)'(1);
          r_state <= (r_rem == (ADDR_WIDTH+1)'(1)) ? DONE : READ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // outputs decode from state and pointers; write data passes straight through from the RAM
  always_comb begin
    busy      = (r_state == READ) || (r_state == WRITE);
    done      = r_state == DONE;
    mem_we    = r_state == WRITE;
    mem_addr  = (r_state == READ) ? r_src : (r_state == WRITE) ? r_dst : '0;
    mem_wdata = (r_state == WRITE) ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: scoreboard bench with a byte-level reference copy model
module tb_mem_copy_dma;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [11:0] src = '0;
  logic [11:0] dst = '0;
  logic [12:0] len = '0;
  logic        busy, done, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  store   [4096];
  logic [7:0]  ref_mem [4096];
  typedef struct {logic [11:0] a; logic [7:0] d;} wr_t;
  wr_t wq[$];
  int  exp_done = 0;
  int  wr_count = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 0;

  mem_copy_dma dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // synchronous RAM: read data valid the cycle after the address
  always @(posedge clk) begin
    mem_rdata <= store[mem_addr];
    if (mem_we) store[mem_addr] <= mem_wdata;
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, ex);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] v);
    store[a] = v;
    ref_mem[a] = v;
  endtask

  // reference: forward byte copy over a shadow memory; only the first 'upto' bytes happen
  task automatic model(input logic [11:0] s, input logic [11:0] d, input int n, input int upto);
    for (int i = 0; i < upto; i++) begin
      logic [11:0] sa, da;
      wr_t w;
      sa = s + i[11:0];
      da = d + i[11:0];
      ref_mem[da] = ref_mem[sa];
      w.a = da;
      w.d = ref_mem[sa];
      wq.push_back(w);
    end
    if (upto == n) exp_done++;
  endtask

  // monitor: pops expected writes/done pulses and checks idle outputs
  always @(negedge clk) if (mon_en) begin
    if (mem_we) begin
      wr_count++;
      if (wq.size() == 0) chk(wq.size() != 0, "unexpected_write", {20'd0, mem_addr}, 0);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk(mem_addr == e.a, "wr_addr", {20'd0, mem_addr}, {20'd0, e.a});
        chk(mem_wdata == e.d, "wr_data", {24'd0, mem_wdata}, {24'd0, e.d});
      end
    end
    if (done) begin
      chk(exp_done > 0, "done_pulse_expected", 1, exp_done);
      if (exp_done > 0) exp_done--;
    end
    if (!busy)
      chk(!mem_we && mem_addr == 0 && mem_wdata == 0, "idle_outputs", {11'd0, mem_we, mem_addr, mem_wdata}, 0);
  end

  task automatic wait_done(input string nm);
    int cyc = 0;
    while (!done && cyc < 9000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(done == 1, nm, done, 1);
  endtask

  task automatic do_copy(input logic [11:0] s, input logic [11:0] d, input int n);
    int cyc = 0;
    int bc = 0;
    model(s, d, n, n);
    src = s; dst = d; len = n[12:0]; start = 1;
    @(posedge clk); #1;
    start = 0;
    while (!done && cyc < 9000) begin
      if (busy) bc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk(done == 1, "done_seen", done, 1);
    chk(cyc == 2 * n, "cycles_to_done", cyc, 2 * n);
    chk(bc == 2 * n, "busy_cycles", bc, 2 * n);
    @(posedge clk); #1;
    chk(done == 0, "done_one_cycle", done, 0);
  endtask

  initial begin
    int wc0, mism;
    for (int i = 0; i < 4096; i++) poke(i[11:0], 8'($urandom));
    repeat (2) @(posedge clk);
    #1;
    chk({busy, done, mem_we, mem_addr, mem_wdata} == 0, "reset_outputs", {busy, done, mem_we, mem_addr, mem_wdata}, 0);
    reset = 0;
    mon_en = 1;
    @(posedge clk); #1;
    // basic four-byte copy
    poke(12'h010, 8'h11); poke(12'h011, 8'h22); poke(12'h012, 8'h33); poke(12'h013, 8'h44);
    do_copy(12'h010, 12'h200, 4);
    chk({store[12'h200], store[12'h201], store[12'h202], store[12'h203]} == 32'h11223344, "basic_copy",
        {store[12'h200], store[12'h201], store[12'h202], store[12'h203]}, 32'h11223344);
    // zero length
    do_copy(12'h123, 12'h456, 0);
    // source wrap
    poke(12'hFFE, 8'hAA); poke(12'hFFF, 8'hBB); poke(12'h000, 8'hCC);
    do_copy(12'hFFE, 12'h100, 3);
    chk({store[12'h100], store[12'h101], store[12'h102]} == 24'hAABBCC, "src_wrap",
        {8'd0, store[12'h100], store[12'h101], store[12'h102]}, 32'hAABBCC);
    // forward overlap
    poke(12'h020, 8'h5A);
    do_copy(12'h020, 12'h021, 3);
    chk({store[12'h021], store[12'h022], store[12'h023]} == 24'h5A5A5A, "fwd_overlap",
        {8'd0, store[12'h021], store[12'h022], store[12'h023]}, 32'h5A5A5A);
    // reset beats start from IDLE
    reset = 1; start = 1; src = 12'h700; dst = 12'h710; len = 13'd5;
    @(posedge clk); #1;
    reset = 0; start = 0;
    chk(!busy && !done, "reset_priority", {busy, done}, 0);
    // reset in the fifth busy cycle abandons the copy after two bytes
    wc0 = wr_count;
    model(12'h400, 12'h500, 8, 2);
    src = 12'h400; dst = 12'h500; len = 13'd8; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) begin @(posedge clk); #1; end
    chk(busy == 1, "abort_busy_before", busy, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk({busy, done, mem_we, mem_addr, mem_wdata} == 0, "abort_outputs", {busy, done, mem_we, mem_addr, mem_wdata}, 0);
    repeat (6) @(posedge clk);
    #1;
    chk(wr_count - wc0 == 2, "abort_writes", wr_count - wc0, 2);
    // start held through a copy: restart only after the DONE cycle
    model(12'h300, 12'h380, 2, 2);
    model(12'h300, 12'h380, 2, 2);
    src = 12'h300; dst = 12'h380; len = 13'd2; start = 1;
    @(posedge clk); #1;
    wait_done("hold_first_done");
    @(posedge clk); #1;
    chk(!busy && !done, "hold_idle_gap", {busy, done}, 0);
    @(posedge clk); #1;
    chk(busy == 1, "hold_restart", busy, 1);
    start = 0;
    wait_done("hold_second_done");
    @(posedge clk); #1;
    // randomized copies, then a full-space copy
    for (int k = 0; k < 20; k++) do_copy(12'($urandom), 12'($urandom), int'($urandom_range(0, 24)));
    do_copy(12'($urandom), 12'($urandom), 4096);
    repeat (3) @(posedge clk);
    #1;
    chk(wq.size() == 0, "writes_outstanding", wq.size(), 0);
    chk(exp_done == 0, "dones_outstanding", exp_done, 0);
    mism = 0;
    for (int i = 0; i < 4096; i++) if (store[i] !== ref_mem[i]) mism++;
    chk(mism == 0, "memory_image", mism, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
